// File: rtl/commit_store_queue.sv
// commit_store_queue: two-level store queue (speculative -> commit) feeding the D$.
// Optional store-to-load hazard detection is built when COMMIT_STORE_QUEUE_FWD_EN is defined.
module commit_store_queue #(
    parameter int SPEC_DEPTH   = 4,
    parameter int COMMIT_DEPTH = 4,
    parameter int PLEN         = 34,
    parameter int XLEN         = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [PLEN-1:0]     paddr_i,
    input  logic [XLEN-1:0]     data_i,
    input  logic [XLEN/8-1:0]   be_i,
    input  logic [1:0]          size_i,
    input  logic                commit_i,
    output logic                commit_ready_o,
    output logic                no_st_pending_o,
    output logic                store_buffer_empty_o,
`ifdef COMMIT_STORE_QUEUE_FWD_EN
    input  logic [11:0]         page_offset_i,
    output logic                page_offset_matches_o,
`endif
    output logic                req_o,
    input  logic                gnt_i,
    output logic [PLEN-1:0]     addr_o,
    output logic [XLEN-1:0]     wdata_o,
    output logic [XLEN/8-1:0]   be_o,
    output logic [1:0]          size_o
);

    localparam int SPW = $clog2(SPEC_DEPTH);
    localparam int CPW = $clog2(COMMIT_DEPTH);
    localparam int BEW = XLEN / 8;
    localparam logic [SPW:0] SPEC_FULL   = (SPW+1)'(SPEC_DEPTH);
    localparam logic [CPW:0] COMMIT_FULL = (CPW+1)'(COMMIT_DEPTH);

    logic [PLEN-1:0] spec_addr [SPEC_DEPTH];
    logic [XLEN-1:0] spec_data [SPEC_DEPTH];
    logic [BEW-1:0]  spec_be   [SPEC_DEPTH];
    logic [1:0]      spec_size [SPEC_DEPTH];

    logic [PLEN-1:0] commit_addr [COMMIT_DEPTH];
    logic [XLEN-1:0] commit_data [COMMIT_DEPTH];
    logic [BEW-1:0]  commit_be   [COMMIT_DEPTH];
    logic [1:0]      commit_size [COMMIT_DEPTH];

    logic [SPW-1:0] spec_rptr, spec_wptr;
    logic [SPW:0]   spec_cnt;
    logic [CPW-1:0] commit_rptr, commit_wptr;
    logic [CPW:0]   commit_cnt;

    logic push, promote, pop;

    // Status flags come straight from the registered counters, so a freed slot shows up next cycle.
    assign ready_o              = spec_cnt < SPEC_FULL;
    assign commit_ready_o       = commit_cnt < COMMIT_FULL;
    assign no_st_pending_o      = commit_cnt == '0;
    assign store_buffer_empty_o = (commit_cnt == '0) && (spec_cnt == '0);
    assign req_o                = commit_cnt != '0;

    // A push arriving on a flush cycle is discarded along with the rest of the speculative state.
    assign push    = valid_i && ready_o && !flush_i;
    assign promote = commit_i && (spec_cnt != '0) && commit_ready_o;
    assign pop     = req_o && gnt_i;

    assign addr_o  = commit_addr[commit_rptr];
    assign wdata_o = commit_data[commit_rptr];
    assign be_o    = commit_be[commit_rptr];
    assign size_o  = commit_size[commit_rptr];

    // Speculative entry storage: written at the tail on every accepted push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SPEC_DEPTH; i++) begin
                spec_addr[i] <= '0;
                spec_data[i] <= '0;
                spec_be[i]   <= '0;
                spec_size[i] <= '0;
            end
        end else if (push) begin
            spec_addr[spec_wptr] <= paddr_i;
            spec_data[spec_wptr] <= data_i;
            spec_be[spec_wptr]   <= be_i;
            spec_size[spec_wptr] <= size_i;
        end
    end

    // Speculative pointers and count; a same-cycle promotion is applied before the flush collapses the queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spec_rptr <= '0;
            spec_wptr <= '0;
            spec_cnt  <= '0;
        end else begin
            if (promote) begin
                spec_rptr <= spec_rptr + SPW'(1);
            end
            if (flush_i) begin
                spec_wptr <= promote ? spec_rptr + SPW'(1) : spec_rptr;
                spec_cnt  <= '0;
            end else begin
                if (push) begin
                    spec_wptr <= spec_wptr + SPW'(1);
                end
                case ({push, promote})
                    2'b10:   spec_cnt <= spec_cnt + (SPW+1)'(1);
                    2'b01:   spec_cnt <= spec_cnt - (SPW+1)'(1);
                    default: spec_cnt <= spec_cnt;
                endcase
            end
        end
    end

    // Commit entry storage: the speculative head is copied to the commit tail on promotion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < COMMIT_DEPTH; i++) begin
                commit_addr[i] <= '0;
                commit_data[i] <= '0;
                commit_be[i]   <= '0;
                commit_size[i] <= '0;
            end
        end else if (promote) begin
            commit_addr[commit_wptr] <= spec_addr[spec_rptr];
            commit_data[commit_wptr] <= spec_data[spec_rptr];
            commit_be[commit_wptr]   <= spec_be[spec_rptr];
            commit_size[commit_wptr] <= spec_size[spec_rptr];
        end
    end

    // Commit pointers and count; never flushed, only drained by granted requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            commit_rptr <= '0;
            commit_wptr <= '0;
            commit_cnt  <= '0;
        end else begin
            if (promote) begin
                commit_wptr <= commit_wptr + CPW'(1);
            end
            if (pop) begin
                commit_rptr <= commit_rptr + CPW'(1);
            end
            case ({promote, pop})
                2'b10:   commit_cnt <= commit_cnt + (CPW+1)'(1);
                2'b01:   commit_cnt <= commit_cnt - (CPW+1)'(1);
                default: commit_cnt <= commit_cnt;
            endcase
        end
    end

`ifdef COMMIT_STORE_QUEUE_FWD_EN
    logic [SPW-1:0] spec_off;
    logic [CPW-1:0] commit_off;

    // Flag any occupied entry in either queue whose doubleword page offset matches the load.
    always_comb begin
        page_offset_matches_o = 1'b0;
        spec_off              = '0;
        commit_off            = '0;
        for (int i = 0; i < SPEC_DEPTH; i++) begin
            spec_off = SPW'(i) - spec_rptr;
            if (({1'b0, spec_off} < spec_cnt) && (spec_addr[i][11:3] == page_offset_i[11:3])) begin
                page_offset_matches_o = 1'b1;
            end
        end
        for (int i = 0; i < COMMIT_DEPTH; i++) begin
            commit_off = CPW'(i) - commit_rptr;
            if (({1'b0, commit_off} < commit_cnt) && (commit_addr[i][11:3] == page_offset_i[11:3])) begin
                page_offset_matches_o = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_commit_store_queue.sv
// Testbench for commit_store_queue: queue-based reference model plus directed scenarios.
module tb_commit_store_queue;

    typedef struct {
        logic [33:0] a;
        logic [63:0] d;
        logic [7:0]  be;
        logic [1:0]  sz;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [33:0] paddr = '0;
    logic [63:0] data = '0;
    logic [7:0]  be = '0;
    logic [1:0]  size = '0;
    logic        commit = 1'b0;
    logic        commit_ready;
    logic        no_st_pending;
    logic        sb_empty;
    logic        req;
    logic        gnt = 1'b0;
    logic [33:0] addr_out;
    logic [63:0] wdata_out;
    logic [7:0]  be_out;
    logic [1:0]  size_out;
`ifdef COMMIT_STORE_QUEUE_FWD_EN
    logic [11:0] page_offset = '0;
    logic        match;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ent_t spec_q[$];
    ent_t com_q[$];

    commit_store_queue dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .flush_i              (flush),
        .valid_i              (valid),
        .ready_o              (ready),
        .paddr_i              (paddr),
        .data_i               (data),
        .be_i                 (be),
        .size_i               (size),
        .commit_i             (commit),
        .commit_ready_o       (commit_ready),
        .no_st_pending_o      (no_st_pending),
        .store_buffer_empty_o (sb_empty),
`ifdef COMMIT_STORE_QUEUE_FWD_EN
        .page_offset_i        (page_offset),
        .page_offset_matches_o(match),
`endif
        .req_o                (req),
        .gnt_i                (gnt),
        .addr_o               (addr_out),
        .wdata_o              (wdata_out),
        .be_o                 (be_out),
        .size_o               (size_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

`ifdef COMMIT_STORE_QUEUE_FWD_EN
    function automatic logic modelMatch(input logic [11:0] po);
        foreach (spec_q[i]) if (spec_q[i].a[11:3] == po[11:3]) return 1'b1;
        foreach (com_q[i])  if (com_q[i].a[11:3] == po[11:3]) return 1'b1;
        return 1'b0;
    endfunction
`endif

    // Reference model: two FIFOs updated from the inputs seen at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_q.delete();
            com_q.delete();
        end else begin
            automatic bit   m_push = valid && (spec_q.size() < 4) && !flush;
            automatic bit   m_prom = commit && (spec_q.size() != 0) && (com_q.size() < 4);
            automatic bit   m_pop  = gnt && (com_q.size() != 0);
            automatic ent_t e;
            if (m_pop) e = com_q.pop_front();
            if (m_prom) com_q.push_back(spec_q.pop_front());
            if (flush) spec_q.delete();
            if (m_push) begin
                e.a = paddr; e.d = data; e.be = be; e.sz = size;
                spec_q.push_back(e);
            end
        end
    end

    // Compare every output against the model shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            checkOutput("m_ready", ready, spec_q.size() < 4);
            checkOutput("m_commit_ready", commit_ready, com_q.size() < 4);
            checkOutput("m_no_st_pending", no_st_pending, com_q.size() == 0);
            checkOutput("m_sb_empty", sb_empty, (com_q.size() == 0) && (spec_q.size() == 0));
            checkOutput("m_req", req, com_q.size() != 0);
            if (com_q.size() != 0) begin
                checkOutput("m_addr", addr_out, com_q[0].a);
                checkOutput("m_wdata", wdata_out, com_q[0].d);
                checkOutput("m_be", be_out, com_q[0].be);
                checkOutput("m_size", size_out, com_q[0].sz);
            end
`ifdef COMMIT_STORE_QUEUE_FWD_EN
            checkOutput("m_match", match, modelMatch(page_offset));
`endif
        end
    end

    task automatic applyStimulus(input logic v, input logic [33:0] a, input logic [63:0] d,
                                 input logic c, input logic f, input logic g);
        valid  = v;
        paddr  = a;
        data   = d;
        be     = 8'hF0 ^ d[7:0];
        size   = d[1:0];
        commit = c;
        flush  = f;
        gnt    = g;
        @(negedge clk);
    endtask

    task automatic drainAll(input string name);
        for (int k = 0; k < 20; k++) begin
            if (no_st_pending) break;
            applyStimulus(0, '0, '0, 0, 0, 1);
        end
        applyStimulus(0, '0, '0, 0, 0, 0);
        checkOutput(name, no_st_pending, 1);
    endtask

    initial begin
        int exp_data;
        // Reset values must appear immediately
        #2;
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_commit_ready", commit_ready, 1);
        checkOutput("rst_no_st_pending", no_st_pending, 1);
        checkOutput("rst_sb_empty", sb_empty, 1);
        checkOutput("rst_req", req, 0);
        checkOutput("rst_addr", addr_out, 0);
        checkOutput("rst_wdata", wdata_out, 0);
        checkOutput("rst_be", be_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fill speculative queue, fifth push dropped
        for (int i = 0; i < 4; i++) applyStimulus(1, 34'h100 + 34'(i * 8), 64'h100 + 64'(i * 8), 0, 0, 0);
        checkOutput("t1_ready_full", ready, 0);
        applyStimulus(1, 34'h3F8, 64'hDEAD, 0, 0, 0);
        checkOutput("t1_ready_still_full", ready, 0);
        checkOutput("t1_no_st_pending", no_st_pending, 1);

        // Promote two and drain them
        applyStimulus(0, '0, '0, 1, 0, 0);
        checkOutput("t2_no_st_pending0", no_st_pending, 0);
        applyStimulus(0, '0, '0, 1, 0, 0);
        checkOutput("t2_req", req, 1);
        checkOutput("t2_addr0", addr_out, 34'h100);
        applyStimulus(0, '0, '0, 0, 0, 1);
        checkOutput("t2_addr1", addr_out, 34'h108);
        applyStimulus(0, '0, '0, 0, 0, 1);
        checkOutput("t2_drained", no_st_pending, 1);

        // Fill the commit queue, extra commit ignored, one grant frees a slot
        applyStimulus(1, 34'h120, 64'h120, 0, 0, 0);
        applyStimulus(1, 34'h128, 64'h128, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, '0, '0, 1, 0, 0);
        checkOutput("t3_commit_full", commit_ready, 0);
        applyStimulus(1, 34'h130, 64'h130, 0, 0, 0);
        applyStimulus(0, '0, '0, 1, 0, 0);
        checkOutput("t3_commit_ignored", commit_ready, 0);
        checkOutput("t3_head", addr_out, 34'h110);
        checkOutput("t3_spec_kept", sb_empty, 0);
        applyStimulus(0, '0, '0, 0, 0, 1);
        checkOutput("t3_commit_ready_again", commit_ready, 1);
        checkOutput("t3_head_next", addr_out, 34'h118);
        applyStimulus(0, '0, '0, 1, 0, 1);
        drainAll("t3_drained");
        checkOutput("t3_sb_empty", sb_empty, 1);

        // Flush with simultaneous promotion and push
        for (int i = 0; i < 3; i++) applyStimulus(1, 34'h200 + 34'(i * 8), 64'h200 + 64'(i * 8), 0, 0, 0);
        applyStimulus(1, 34'h300, 64'h300, 1, 1, 0);
        checkOutput("t4_promoted_kept", no_st_pending, 0);
        checkOutput("t4_head", addr_out, 34'h200);
        checkOutput("t4_ready", ready, 1);
        applyStimulus(0, '0, '0, 0, 0, 1);
        checkOutput("t4_all_empty", sb_empty, 1);

        // Steady-state streaming of 32 stores
        exp_data = 0;
        for (int i = 0; i < 34; i++) begin
            if (req) begin
                checkOutput("t5_wdata", wdata_out, 64'(exp_data));
                exp_data++;
            end
            applyStimulus(i < 32, 34'h1000 + 34'(i * 8), 64'(i), 1, 0, 1);
        end
        checkOutput("t5_count", 64'(exp_data), 32);
        checkOutput("t5_sb_empty", sb_empty, 1);

        // Reset in the middle of a drain
        applyStimulus(1, 34'h400, 64'h400, 0, 0, 0);
        applyStimulus(1, 34'h408, 64'h408, 1, 0, 0);
        applyStimulus(0, '0, '0, 1, 0, 0);
        checkOutput("t6_req_before", req, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_req_dropped", req, 0);
        checkOutput("t6_no_st_pending", no_st_pending, 1);
        checkOutput("t6_sb_empty", sb_empty, 1);
        checkOutput("t6_addr", addr_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, '0, '0, 0, 0, 0);

`ifdef COMMIT_STORE_QUEUE_FWD_EN
        // Page-offset hazard detection
        applyStimulus(1, 34'h2A8, 64'h2A8, 0, 0, 0);
        page_offset = 12'h2A8;
        #1 checkOutput("t7_match_hit", match, 1);
        page_offset = 12'h2B0;
        #1 checkOutput("t7_match_miss", match, 0);
        page_offset = 12'h2A8;
        @(negedge clk);
        applyStimulus(0, '0, '0, 1, 0, 0);
        drainAll("t7_drained");
        #1 checkOutput("t7_match_after_drain", match, 0);
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
